eth_measurer_scheduler: RTL and testbench

ETH_MEASURER_SCHEDULER -- requirements
Module: eth_measurer_scheduler

---
 rtl/eth_measurer_pkg.sv | 19 +
 rtl/eth_measurer_scheduler_if.sv | 21 ++
 rtl/eth_measurer_counter.sv | 35 +++
 rtl/eth_measurer_scheduler.sv | 169 ++++++++++++++++
 tb/tb_eth_measurer_scheduler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_measurer_pkg.sv
// Shared types and constants for the Ethernet ping/pong latency measurer scheduler.
package eth_measurer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_PERIOD = 2'd1,
        ST_REQUEST     = 2'd2,
        ST_WAIT_PONG   = 2'd3
    } state_e;

    localparam logic RESULT_OK   = 1'b0;
    localparam logic RESULT_LOST = 1'b1;

    // True once cnt+1 cycles have elapsed relative to limit; widened so limit=0 and cnt=max behave.
    function automatic logic period_elapsed(input logic [31:0] cnt, input logic [31:0] limit);
        return ({1'b0, cnt} + 33'd1) >= {1'b0, limit};
    endfunction

endpackage

// File: rtl/eth_measurer_scheduler_if.sv
// Ping request / pong receive / result bus between the scheduler and the measurer datapath.
interface eth_measurer_scheduler_if;
    logic        ping_req;
    logic        ping_ack;
    logic [31:0] ping_id;
    logic        pong_valid;
    logic [31:0] pong_id;
    logic        result_valid;
    logic        result_lost;
    logic [63:0] result_latency;

    modport master (
        output ping_req, ping_id, result_valid, result_lost, result_latency,
        input  ping_ack, pong_valid, pong_id
    );

    modport slave (
        input  ping_req, ping_id, result_valid, result_lost, result_latency,
        output ping_ack, pong_valid, pong_id
    );
endinterface

// File: rtl/eth_measurer_counter.sv
// Saturating up-counter with synchronous clear, count enable and freeze.
module eth_measurer_counter #(
    parameter int width = 32
) (
    input  logic             s_axi_clk,
    input  logic             s_axi_resetn,
    input  logic             clear,
    input  logic             en,
    input  logic             freeze,
    output logic [width-1:0] count
);

    logic [width-1:0] count_q, count_d;

    // Saturation keeps a long-idle counter from wrapping back below its limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !freeze && (count_q != {width{1'b1}})) begin
            count_d = count_q + width'(1);
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eth_measurer_scheduler.sv
// Periodically issues pings, matches returning pongs by id, and reports latency or loss.
//
// state          | meaning
// ST_IDLE        | scheduling off, waiting for enable && time_running
// ST_WAIT_PERIOD | result reported, waiting for period since last issue
// ST_REQUEST     | ping_req held high until ping_ack
// ST_WAIT_PONG   | ping issued, waiting for matching pong or timeout
module eth_measurer_scheduler
    import eth_measurer_pkg::*;
#(
    parameter int          counter_width  = 64,
    parameter logic [31:0] id_reset_value = 32'h0000_0000
) (
    input  logic                     s_axi_clk,
    input  logic                     s_axi_resetn,
    input  logic                     enable,
    input  logic [31:0]              period,
    input  logic [31:0]              timeout,
    input  logic [63:0]              current_time,
    input  logic                     time_running,
    eth_measurer_scheduler_if.master bus,
    output logic [counter_width-1:0] ping_count,
    output logic [counter_width-1:0] pong_count,
    output logic [counter_width-1:0] lost_count,
    output logic                     busy
);

    state_e                   state_q, state_d;
    logic                     ping_req_q, ping_req_d;
    logic [31:0]              ping_id_q, ping_id_d;
    logic                     result_valid_q, result_valid_d;
    logic                     result_lost_q, result_lost_d;
    logic [63:0]              result_latency_q, result_latency_d;
    logic [63:0]              issue_time_q, issue_time_d;
    logic [counter_width-1:0] ping_count_q, ping_count_d;
    logic [counter_width-1:0] pong_count_q, pong_count_d;
    logic [counter_width-1:0] lost_count_q, lost_count_d;
    logic                     busy_q, busy_d;

    logic [31:0] period_cnt, timeout_cnt;
    logic        handshake, pong_hit, timed_out;

    // The whole FSM holds while the timer is stopped, including a pending handshake.
    assign handshake = (state_q == ST_REQUEST) && ping_req_q && bus.ping_ack && time_running;
    assign pong_hit  = (state_q == ST_WAIT_PONG) && time_running && bus.pong_valid
                       && (bus.pong_id == ping_id_q);
    assign timed_out = (state_q == ST_WAIT_PONG) && time_running && (timeout_cnt >= timeout);

    eth_measurer_counter #(.width(32)) u_period_cnt (
        .s_axi_clk    (s_axi_clk),
        .s_axi_resetn (s_axi_resetn),
        .clear        (handshake),
        .en           (state_q != ST_IDLE),
        .freeze       (!time_running),
        .count        (period_cnt)
    );

    eth_measurer_counter #(.width(32)) u_timeout_cnt (
        .s_axi_clk    (s_axi_clk),
        .s_axi_resetn (s_axi_resetn),
        .clear        (handshake),
        .en           (state_q == ST_WAIT_PONG),
        .freeze       (!time_running),
        .count        (timeout_cnt)
    );

    always_comb begin
        state_d          = state_q;
        ping_req_d       = ping_req_q;
        ping_id_d        = ping_id_q;
        result_valid_d   = 1'b0;
        result_lost_d    = result_lost_q;
        result_latency_d = result_latency_q;
        issue_time_d     = issue_time_q;
        ping_count_d     = ping_count_q;
        pong_count_d     = pong_count_q;
        lost_count_d     = lost_count_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && time_running) begin
                    state_d    = ST_REQUEST;
                    ping_req_d = 1'b1;
                end
            end
            ST_WAIT_PERIOD: begin
                if (time_running) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (period_elapsed(period_cnt, period)) begin
                        state_d    = ST_REQUEST;
                        ping_req_d = 1'b1;
                    end
                end
            end
            ST_REQUEST: begin
                if (handshake) begin
                    state_d      = ST_WAIT_PONG;
                    ping_req_d   = 1'b0;
                    issue_time_d = current_time;
                    ping_count_d = ping_count_q + counter_width'(1);
                end
            end
            ST_WAIT_PONG: begin
                // A matching pong wins over a timeout landing in the same cycle.
                if (pong_hit) begin
                    state_d          = ST_WAIT_PERIOD;
                    result_valid_d   = 1'b1;
                    result_lost_d    = RESULT_OK;
                    result_latency_d = current_time - issue_time_q;
                    pong_count_d     = pong_count_q + counter_width'(1);
                    ping_id_d        = ping_id_q + 32'd1;
                end else if (timed_out) begin
                    state_d          = ST_WAIT_PERIOD;
                    result_valid_d   = 1'b1;
                    result_lost_d    = RESULT_LOST;
                    result_latency_d = 64'd0;
                    lost_count_d     = lost_count_q + counter_width'(1);
                    ping_id_d        = ping_id_q + 32'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ping_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            state_q          <= ST_IDLE;
            ping_req_q       <= 1'b0;
            ping_id_q        <= id_reset_value;
            result_valid_q   <= 1'b0;
            result_lost_q    <= 1'b0;
            result_latency_q <= 64'd0;
            issue_time_q     <= 64'd0;
            ping_count_q     <= '0;
            pong_count_q     <= '0;
            lost_count_q     <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            ping_req_q       <= ping_req_d;
            ping_id_q        <= ping_id_d;
            result_valid_q   <= result_valid_d;
            result_lost_q    <= result_lost_d;
            result_latency_q <= result_latency_d;
            issue_time_q     <= issue_time_d;
            ping_count_q     <= ping_count_d;
            pong_count_q     <= pong_count_d;
            lost_count_q     <= lost_count_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.ping_req       = ping_req_q;
    assign bus.ping_id        = ping_id_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.result_lost    = result_lost_q;
    assign bus.result_latency = result_latency_q;
    assign ping_count         = ping_count_q;
    assign pong_count         = pong_count_q;
    assign lost_count         = lost_count_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_eth_measurer_scheduler.sv
// Directed bench for eth_measurer_scheduler: vector table of ping exchanges plus corner sequences.
module tb_eth_measurer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        enable, enable2, time_running;
    logic [31:0] period, timeout, period2, timeout2;
    logic [63:0] current_time;
    logic [63:0] ping_count, pong_count, lost_count;
    logic [63:0] ping_count2, pong_count2, lost_count2;
    logic        busy, busy2;

    eth_measurer_scheduler_if bus();
    eth_measurer_scheduler_if bus2();

    eth_measurer_scheduler #(.counter_width(64)) dut (
        .s_axi_clk    (clk),
        .s_axi_resetn (rst_n),
        .enable       (enable),
        .period       (period),
        .timeout      (timeout),
        .current_time (current_time),
        .time_running (time_running),
        .bus          (bus),
        .ping_count   (ping_count),
        .pong_count   (pong_count),
        .lost_count   (lost_count),
        .busy         (busy)
    );

    eth_measurer_scheduler #(.counter_width(64), .id_reset_value(32'hFFFF_FFFF)) dut2 (
        .s_axi_clk    (clk),
        .s_axi_resetn (rst2_n),
        .enable       (enable2),
        .period       (period2),
        .timeout      (timeout2),
        .current_time (current_time),
        .time_running (1'b1),
        .bus          (bus2),
        .ping_count   (ping_count2),
        .pong_count   (pong_count2),
        .lost_count   (lost_count2),
        .busy         (busy2)
    );

    always #5 clk = ~clk;

    initial begin
        current_time = 64'd1000;
        forever begin
            @(negedge clk);
            current_time = current_time + 64'd1;
        end
    end

    typedef struct {
        logic [31:0] period;
        logic [31:0] timeout;
        int          pong_at;
        int          bad_at;
        int          exp_cycle;
        logic        exp_lost;
        logic [63:0] exp_lat;
        int          exp_gap;
    } vec_t;

    vec_t        vecs[7];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_ping = 0, exp_pong = 0, exp_lost = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!bus.ping_req && k < 300) begin
            step();
            k++;
        end
        check(name, {63'd0, bus.ping_req}, 64'd1);
    endtask

    task automatic check_counts(input string name);
        check({name, "_ping_cnt"}, ping_count, exp_ping);
        check({name, "_pong_cnt"}, pong_count, exp_pong);
        check({name, "_lost_cnt"}, lost_count, exp_lost);
    endtask

    task automatic run_ping(input vec_t v, input int idx);
        logic [31:0] id0;
        int          k;
        bit          got;
        period  = v.period;
        timeout = v.timeout;
        wait_req($sformatf("v%0d_req", idx));
        id0 = bus.ping_id;
        bus.ping_ack = 1'b1;
        step();
        bus.ping_ack = 1'b0;
        exp_ping++;
        check($sformatf("v%0d_req_drop", idx), {63'd0, bus.ping_req}, 64'd0);
        got = 1'b0;
        k   = 0;
        while (!got && k < 200) begin
            k++;
            bus.pong_valid = (k == v.pong_at) || (k == v.bad_at);
            bus.pong_id    = (k == v.pong_at) ? id0 : id0 + 32'd5;
            step();
            bus.pong_valid = 1'b0;
            got = bus.result_valid;
        end
        check($sformatf("v%0d_cycle", idx), 64'(k), 64'(v.exp_cycle));
        check($sformatf("v%0d_lost", idx), {63'd0, bus.result_lost}, {63'd0, v.exp_lost});
        check($sformatf("v%0d_latency", idx), bus.result_latency, v.exp_lat);
        check($sformatf("v%0d_next_id", idx), {32'd0, bus.ping_id}, {32'd0, id0 + 32'd1});
        if (v.exp_lost) exp_lost++;
        else            exp_pong++;
        check_counts($sformatf("v%0d", idx));
        step();
        k++;
        check($sformatf("v%0d_strobe", idx), {63'd0, bus.result_valid}, 64'd0);
        while (!bus.ping_req && k < 400) begin
            step();
            k++;
        end
        check($sformatf("v%0d_gap", idx), 64'(k), 64'(v.exp_gap));
    endtask

    initial begin
        logic [31:0] id_hold;
        int          k;
        bit          seen;

        //            period timeout pong bad cycle lost  lat     gap
        vecs[0] = '{32'd100, 32'd50, 20, 0, 20, 1'b0, 64'd20, 100};
        vecs[1] = '{32'd100, 32'd50,  0, 0, 51, 1'b1, 64'd0,  100};
        vecs[2] = '{32'd100, 32'd50, 51, 0, 51, 1'b0, 64'd51, 100};
        vecs[3] = '{32'd10,  32'd5,   3, 2,  3, 1'b0, 64'd3,   10};
        vecs[4] = '{32'd10,  32'd5,   0, 4,  6, 1'b1, 64'd0,   10};
        vecs[5] = '{32'd1,   32'd0,   0, 0,  1, 1'b1, 64'd0,    2};
        vecs[6] = '{32'd0,   32'd0,   1, 0,  1, 1'b0, 64'd1,    2};

        rst_n = 1'b0; rst2_n = 1'b0;
        enable = 1'b0; enable2 = 1'b0; time_running = 1'b0;
        period = 32'd100; timeout = 32'd50; period2 = 32'd0; timeout2 = 32'd2;
        bus.ping_ack = 1'b0; bus.pong_valid = 1'b0; bus.pong_id = 32'd0;
        bus2.ping_ack = 1'b0; bus2.pong_valid = 1'b0; bus2.pong_id = 32'd0;
        step(); step();

        check("rst_ping_req", {63'd0, bus.ping_req}, 64'd0);
        check("rst_ping_id", {32'd0, bus.ping_id}, 64'd0);
        check("rst_result_valid", {63'd0, bus.result_valid}, 64'd0);
        check("rst_result_lost", {63'd0, bus.result_lost}, 64'd0);
        check("rst_latency", bus.result_latency, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check_counts("rst");

        rst_n  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("frozen_busy", {63'd0, busy}, 64'd0);
        check("frozen_req", {63'd0, bus.ping_req}, 64'd0);
        time_running = 1'b1;

        for (int i = 0; i < 7; i++) run_ping(vecs[i], i);

        // ack withheld: request and id must hold, latency counted from the ack edge
        period  = 32'd20;
        timeout = 32'd50;
        id_hold = bus.ping_id;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_req", {63'd0, bus.ping_req}, 64'd1);
            check("hold_id", {32'd0, bus.ping_id}, {32'd0, id_hold});
        end
        bus.ping_ack = 1'b1;
        step();
        bus.ping_ack = 1'b0;
        exp_ping++;
        for (int i = 1; i <= 7; i++) begin
            bus.pong_valid = (i == 7);
            bus.pong_id    = id_hold;
            step();
            bus.pong_valid = 1'b0;
        end
        check("hold_result_valid", {63'd0, bus.result_valid}, 64'd1);
        check("hold_latency", bus.result_latency, 64'd7);
        exp_pong++;
        check_counts("hold");

        // enable dropped mid-wait: result still delivered, then back to idle for good
        wait_req("dis_req");
        id_hold = bus.ping_id;
        bus.ping_ack = 1'b1;
        step();
        bus.ping_ack = 1'b0;
        exp_ping++;
        enable = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.pong_valid = (i == 5);
            bus.pong_id    = id_hold;
            step();
            bus.pong_valid = 1'b0;
        end
        check("dis_result_valid", {63'd0, bus.result_valid}, 64'd1);
        check("dis_result_lost", {63'd0, bus.result_lost}, 64'd0);
        check("dis_latency", bus.result_latency, 64'd5);
        exp_pong++;
        step();
        check("dis_busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (bus.ping_req) seen = 1'b1;
        end
        check("dis_no_req", {63'd0, seen}, 64'd0);
        check_counts("dis");

        // id wrap on second instance, then reset while requesting
        rst2_n  = 1'b1;
        enable2 = 1'b1;
        k = 0;
        while (!bus2.ping_req && k < 20) begin step(); k++; end
        check("wrap_req0", {63'd0, bus2.ping_req}, 64'd1);
        check("wrap_id0", {32'd0, bus2.ping_id}, 64'hFFFF_FFFF);
        bus2.ping_ack = 1'b1;
        step();
        bus2.ping_ack = 1'b0;
        k = 0;
        while (!bus2.result_valid && k < 10) begin step(); k++; end
        check("wrap_lost", {63'd0, bus2.result_lost}, 64'd1);
        check("wrap_id_after", {32'd0, bus2.ping_id}, 64'd0);
        k = 0;
        while (!bus2.ping_req && k < 20) begin step(); k++; end
        check("wrap_req1", {63'd0, bus2.ping_req}, 64'd1);
        check("wrap_id1", {32'd0, bus2.ping_id}, 64'd0);
        #2;
        rst2_n = 1'b0;
        #1;
        check("async_rst_req", {63'd0, bus2.ping_req}, 64'd0);
        check("async_rst_busy", {63'd0, busy2}, 64'd0);
        check("async_rst_id", {32'd0, bus2.ping_id}, 64'hFFFF_FFFF);
        check("async_rst_pings", ping_count2, 64'd0);
        enable2 = 1'b0;
        rst2_n  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus2.result_valid) seen = 1'b1;
        end
        check("async_rst_no_result", {63'd0, seen}, 64'd0);
        check("async_rst_counts", pong_count2 | lost_count2, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
